vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync controller.
- Generates H_SYNC, V_SYNC and RGB_EN for any VGA/VESA mode from per-region parameters.
- The vertical counter counts lines, not clocks.
- Adds a pixel-clock enable, programmable sync polarity, a run/stop enable, pixel X/Y coordinates and line/frame start strobes.
- Sits between the top-level clock/reset and the pixel generator / frame-buffer reader.

Parameters:
- CW, 12, width of the internal counters and of the X/Y outputs.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- H_POL, 0, H_SYNC level during the sync region (0 = active-low).
- V_POL, 0, V_SYNC level during the sync region.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- PIX_CE  in  1  pixel clock enable; counters advance only on CLK edges where PIX_CE=1
- EN  in  1  run enable; 0 holds the generator idle at (0,0)
- H_SYNC  out  1  horizontal sync, polarity set by H_POL
- V_SYNC  out  1  vertical sync, polarity set by V_POL
- RGB_EN  out  1  high while the pixel is visible (x<H_ACTIVE and y<V_ACTIVE)
- PIX_X  out  CW  current horizontal count, 0..H_TOTAL-1
- PIX_Y  out  CW  current line count, 0..V_TOTAL-1
- LINE_START  out  1  one-CLK pulse when PIX_X enters 0
- FRAME_START  out  1  one-CLK pulse when (PIX_X,PIX_Y) enters (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be less than 2^CW; otherwise behaviour is undefined.
  - Every region must be at least 1.
- Region order within a line or frame, starting at count 0:
  - active [0, ACTIVE)
  - front porch [ACTIVE, ACTIVE+FP)
  - sync [ACTIVE+FP, ACTIVE+FP+SYNC)
  - back porch, up to TOTAL-1
- All outputs are registered. They are decoded from the counters' next-state value, so in any cycle the outputs match PIX_X/PIX_Y exactly: zero skew, no pipeline lag.
- Reset (RST=1, any time, asynchronous):
  - counters = 0
  - PIX_X = PIX_Y = 0
  - RGB_EN = 0, LINE_START = 0, FRAME_START = 0
  - H_SYNC = ~H_POL, V_SYNC = ~V_POL
- EN=0 (synchronous, not gated by PIX_CE): on the next CLK, counters and outputs go to their reset values and are held there.
- EN rising: the first CE edge does not advance the counters. It loads the (0,0) decode, so RGB_EN=1, LINE_START=1 and FRAME_START=1 for that cycle. Subsequent CE edges advance normally.
- Advance rules, per CE edge while running:
  - If x < H_TOTAL-1: x+1.
  - Else: x=0, and y = (y==V_TOTAL-1) ? 0 : y+1.
- PIX_CE=0 with EN=1: counters, sync levels, RGB_EN, PIX_X and PIX_Y hold. LINE_START and FRAME_START drop to 0, so each strobe is exactly one CLK wide regardless of the CE ratio.
- Sync decode:
  - H_SYNC = H_POL when x is in the sync region, else ~H_POL.
  - V_SYNC = V_POL when y is in the sync region, else ~V_POL, for the whole line including the horizontal blanking.
- RGB_EN: 1 only when x<H_ACTIVE and y<V_ACTIVE. Forced to 0 in every blanking interval.
- LINE_START: high for the one CLK after a CE edge that set x=0.
- FRAME_START: same as LINE_START, but requires both x=0 and y=0. FRAME_START implies LINE_START in the same cycle.
- Simultaneous events:
  - RST overrides EN and PIX_CE.
  - EN=0 overrides PIX_CE.
  - The end-of-line and end-of-frame wraps occur on the same CE edge with no dead cycle.
- Reset mid-line: outputs return to idle immediately, with no partial sync pulse completed. After release, the frame restarts at (0,0).

Test Plan:
- Default params, PIX_CE=1, EN=1 after reset -> FRAME_START at cycle 0; RGB_EN high 640 cycles per line; H_SYNC low for x=656..751; period 800; next FRAME_START 420000 cycles later.
- Default params, V_SYNC check -> V_SYNC low exactly on lines 490..491 (1600 cycles); RGB_EN=0 on lines 480..524; PIX_Y wraps 524->0 with FRAME_START.
- Small mode (H 4/1/2/1, V 3/1/1/1, H_POL=V_POL=1) -> 8-cycle lines, H_SYNC high at x=5,6; 48-cycle frames; V_SYNC high on line 4.
- PIX_CE toggled 1-of-2 (default params) -> each PIX_X value held 2 CLKs; line = 1600 CLKs; LINE_START and FRAME_START exactly 1 CLK wide.
- EN dropped at PIX_X=300, PIX_Y=100, then raised 5 cycles later -> next CLK shows idle outputs (H_SYNC=1, V_SYNC=1, RGB_EN=0, X=Y=0); on re-enable FRAME_START pulses and counting resumes from (0,0).
- RST asserted asynchronously mid-sync-pulse (x=700) -> H_SYNC returns to 1 without waiting for a clock; all outputs stay at reset values until release; first CE edge after release gives FRAME_START=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA sync generator: line/frame counters with registered sync,
// visible-area and start-strobe outputs decoded from the counters' next state.
module vga_timing_gen #(
  parameter int unsigned CW       = 12,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  // Sync widths carry a _W suffix so they do not collide with the sync output ports.
  parameter int unsigned H_SYNC_W = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC_W = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PIX_CE,
  input  logic          EN,
  output logic          H_SYNC,
  output logic          V_SYNC,
  output logic          RGB_EN,
  output logic [CW-1:0] PIX_X,
  output logic [CW-1:0] PIX_Y,
  output logic          LINE_START,
  output logic          FRAME_START
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC_W + V_BP;

  localparam logic [CW-1:0] HLast     = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast     = CW'(VTotal - 1);
  localparam logic [CW-1:0] HAct      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VAct      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_ACTIVE + H_FP + H_SYNC_W);
  localparam logic [CW-1:0] VSyncBeg  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd  = CW'(V_ACTIVE + V_FP + V_SYNC_W);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          rgb_en_q, rgb_en_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    rgb_en_d      = rgb_en_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!EN) begin
      state_d  = StIdle;
      x_d      = '0;
      y_d      = '0;
      h_sync_d = ~H_POL;
      v_sync_d = ~V_POL;
      rgb_en_d = 1'b0;
    end else if (PIX_CE) begin
      // The first CE edge after idle only loads the (0,0) decode.
      if (state_q == StRun) begin
        if (x_q == HLast) begin
          x_d = '0;
          y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end else begin
        x_d = '0;
        y_d = '0;
      end
      state_d       = StRun;
      h_sync_d      = ((x_d >= HSyncBeg) && (x_d < HSyncEnd)) ? H_POL : ~H_POL;
      v_sync_d      = ((y_d >= VSyncBeg) && (y_d < VSyncEnd)) ? V_POL : ~V_POL;
      rgb_en_d      = (x_d < HAct) && (y_d < VAct);
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      rgb_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      rgb_en_q      <= rgb_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign H_SYNC      = h_sync_q;
  assign V_SYNC      = v_sync_q;
  assign RGB_EN      = rgb_en_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 mode share stimulus
// and are both checked every cycle against a frame-index model.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic PIX_CE = 1'b0;
  logic EN = 1'b0;

  logic        hs [2];
  logic        vs [2];
  logic        rgb [2];
  logic        ls [2];
  logic        fs [2];
  logic [11:0] px [2];
  logic [11:0] py [2];

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  // Mode tables: index 0 = default 640x480, index 1 = H 4/1/2/1, V 3/1/1/1, positive sync.
  int ha [2] = '{640, 4};
  int hf [2] = '{16, 1};
  int hw [2] = '{96, 2};
  int hb [2] = '{48, 1};
  int va [2] = '{480, 3};
  int vf [2] = '{10, 1};
  int vw [2] = '{2, 1};
  int vb [2] = '{33, 1};
  int hp [2] = '{0, 1};
  int vp [2] = '{0, 1};

  always #5 CLK = ~CLK;

  vga_timing_gen u_def (
    .CLK(CLK), .RST(RST), .PIX_CE(PIX_CE), .EN(EN),
    .H_SYNC(hs[0]), .V_SYNC(vs[0]), .RGB_EN(rgb[0]), .PIX_X(px[0]), .PIX_Y(py[0]),
    .LINE_START(ls[0]), .FRAME_START(fs[0])
  );

  vga_timing_gen #(
    .CW(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC_W(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC_W(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_small (
    .CLK(CLK), .RST(RST), .PIX_CE(PIX_CE), .EN(EN),
    .H_SYNC(hs[1]), .V_SYNC(vs[1]), .RGB_EN(rgb[1]), .PIX_X(px[1]), .PIX_Y(py[1]),
    .LINE_START(ls[1]), .FRAME_START(fs[1])
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: position is a single pixel index within the frame.
  int unsigned idx [2] = '{0, 0};
  bit          run [2] = '{1'b0, 1'b0};
  bit          fresh [2] = '{1'b0, 1'b0};

  always @(posedge CLK or posedge RST) begin
    for (int m = 0; m < 2; m++) begin
      if (RST || !EN) begin
        run[m] = 1'b0;
        idx[m] = 0;
        fresh[m] = 1'b0;
      end else if (PIX_CE) begin
        if (!run[m]) begin
          run[m] = 1'b1;
          idx[m] = 0;
        end else begin
          idx[m] = (idx[m] + 1) % ((ha[m] + hf[m] + hw[m] + hb[m]) *
                                   (va[m] + vf[m] + vw[m] + vb[m]));
        end
        fresh[m] = 1'b1;
      end else begin
        fresh[m] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        int ht, x, y, e_hs, e_vs, e_rgb, e_ls, e_fs;
        ht = ha[m] + hf[m] + hw[m] + hb[m];
        x = run[m] ? int'(idx[m]) % ht : 0;
        y = run[m] ? int'(idx[m]) / ht : 0;
        e_hs = (run[m] && x >= ha[m] + hf[m] && x < ha[m] + hf[m] + hw[m]) ? hp[m] : 1 - hp[m];
        e_vs = (run[m] && y >= va[m] + vf[m] && y < va[m] + vf[m] + vw[m]) ? vp[m] : 1 - vp[m];
        e_rgb = (run[m] && x < ha[m] && y < va[m]) ? 1 : 0;
        e_ls = (run[m] && fresh[m] && x == 0) ? 1 : 0;
        e_fs = (run[m] && fresh[m] && x == 0 && y == 0) ? 1 : 0;
        chk($sformatf("m%0d_pix_x", m), int'(px[m]), x);
        chk($sformatf("m%0d_pix_y", m), int'(py[m]), y);
        chk($sformatf("m%0d_h_sync", m), int'(hs[m]), e_hs);
        chk($sformatf("m%0d_v_sync", m), int'(vs[m]), e_vs);
        chk($sformatf("m%0d_rgb_en", m), int'(rgb[m]), e_rgb);
        chk($sformatf("m%0d_line_start", m), int'(ls[m]), e_ls);
        chk($sformatf("m%0d_frame_start", m), int'(fs[m]), e_fs);
      end
    end
  end

  task automatic wait_x(input int target);
    int n;
    n = 0;
    while (int'(px[0]) != target && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("reach_x_%0d", target), int'(px[0]), target);
  endtask

  initial begin
    #1 RST = 1'b1;
    @(negedge CLK);
    armed = 1'b1;
    @(negedge CLK);
    chk("rst_def_h_sync", int'(hs[0]), 1);
    chk("rst_def_v_sync", int'(vs[0]), 1);
    chk("rst_small_h_sync", int'(hs[1]), 0);
    chk("rst_def_rgb_en", int'(rgb[0]), 0);

    // Continuous CE: pixel k of the first line lands k cycles after the start edge.
    RST = 1'b0;
    EN = 1'b1;
    PIX_CE = 1'b1;
    @(negedge CLK);
    chk("start_frame_start", int'(fs[0]), 1);
    chk("start_line_start", int'(ls[0]), 1);
    chk("start_rgb_en", int'(rgb[0]), 1);
    for (int k = 1; k <= 800; k++) begin
      @(negedge CLK);
      case (k)
        5:   chk("small_x5_h_sync", int'(hs[1]), 1);
        31:  chk("small_line3_v_sync", int'(vs[1]), 0);
        32:  chk("small_line4_v_sync", int'(vs[1]), 1);
        48:  chk("small_frame_wrap", int'(fs[1]), 1);
        639: chk("def_x639_rgb_en", int'(rgb[0]), 1);
        640: chk("def_x640_rgb_en", int'(rgb[0]), 0);
        655: chk("def_x655_h_sync", int'(hs[0]), 1);
        656: chk("def_x656_h_sync", int'(hs[0]), 0);
        751: chk("def_x751_h_sync", int'(hs[0]), 0);
        752: chk("def_x752_h_sync", int'(hs[0]), 1);
        800: begin
          chk("def_line_wrap_y", int'(py[0]), 1);
          chk("def_line_wrap_ls", int'(ls[0]), 1);
        end
        default: ;
      endcase
    end

    // CE at 1-of-2.
    for (int k = 0; k < 2000; k++) begin
      PIX_CE = k[0];
      @(negedge CLK);
    end
    PIX_CE = 1'b1;

    // EN drop and restart.
    wait_x(300);
    EN = 1'b0;
    @(negedge CLK);
    chk("en_off_h_sync", int'(hs[0]), 1);
    chk("en_off_pix_x", int'(px[0]), 0);
    chk("en_off_rgb_en", int'(rgb[0]), 0);
    repeat (4) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    chk("en_on_frame_start", int'(fs[0]), 1);

    // Async reset in the middle of the sync pulse.
    wait_x(700);
    chk("mid_sync_low", int'(hs[0]), 0);
    #2 RST = 1'b1;
    #1 chk("async_rst_h_sync", int'(hs[0]), 1);
    chk("async_rst_pix_x", int'(px[0]), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_release_frame_start", int'(fs[0]), 1);

    // Randomised CE, EN and asynchronous reset pulses.
    for (int k = 0; k < 6000; k++) begin
      PIX_CE = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) EN = ~EN;
      else if (!EN && $urandom_range(0, 7) == 0) EN = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        #2 RST = 1'b1;
        #4 RST = 1'b0;
      end
      @(negedge CLK);
    end

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
